// File: rtl/sb_rd_tracker.sv
// Scoreboard destination-register tracker: a circular buffer of in-flight rd/type/thread
// entries, allocated at issue and retired in order at commit, exported per entry to the RAW checker.

package config_pkg;

    typedef struct packed {
        int unsigned NR_SB_ENTRIES;
        int unsigned TRANS_ID_BITS;
        int unsigned NUM_THREADS_LOG;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{
        NR_SB_ENTRIES:   8,
        TRANS_ID_BITS:   3,
        NUM_THREADS_LOG: 1
    };

    localparam int unsigned REG_ADDR_SIZE = 6;

endpackage

module sb_rd_tracker #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic                                                         clk_i,
    input  logic                                                         rst_i,
    input  logic                                                         flush_i,

    input  logic                                                         issue_valid_i,
    output logic                                                         issue_ready_o,
    input  logic [config_pkg::REG_ADDR_SIZE-1:0]                         issue_rd_i,
    input  logic                                                         issue_rd_fpr_i,
    input  logic [CVA6Cfg.NUM_THREADS_LOG-1:0]                           issue_thread_id_i,
    output logic [CVA6Cfg.TRANS_ID_BITS-1:0]                             issue_trans_id_o,

    input  logic                                                         commit_valid_i,
    output logic                                                         commit_ready_o,
    output logic [CVA6Cfg.TRANS_ID_BITS-1:0]                             commit_trans_id_o,
    output logic [config_pkg::REG_ADDR_SIZE-1:0]                         commit_rd_o,
    output logic                                                         commit_rd_fpr_o,
    output logic [CVA6Cfg.NUM_THREADS_LOG-1:0]                           commit_thread_id_o,

    output logic [CVA6Cfg.NR_SB_ENTRIES-1:0][config_pkg::REG_ADDR_SIZE-1:0] rd_o,
    output logic [CVA6Cfg.NR_SB_ENTRIES-1:0]                             rd_fpr_o,
    output logic [CVA6Cfg.NR_SB_ENTRIES-1:0][CVA6Cfg.NUM_THREADS_LOG-1:0] thread_ids_o,
    output logic [CVA6Cfg.NR_SB_ENTRIES-1:0]                             still_issued_o,
    output logic [CVA6Cfg.TRANS_ID_BITS-1:0]                             issue_pointer_o,
    output logic [CVA6Cfg.TRANS_ID_BITS:0]                               count_o
);

    localparam int unsigned NR_ENTRIES = CVA6Cfg.NR_SB_ENTRIES;
    localparam int unsigned TID_BITS   = CVA6Cfg.TRANS_ID_BITS;
    localparam int unsigned THR_BITS   = CVA6Cfg.NUM_THREADS_LOG;
    localparam int unsigned RA_BITS    = config_pkg::REG_ADDR_SIZE;

    localparam logic [TID_BITS:0] COUNT_FULL = (TID_BITS+1)'(NR_ENTRIES);

    logic [TID_BITS-1:0]                   issue_ptr_q;
    logic [TID_BITS-1:0]                   commit_ptr_q;
    logic [TID_BITS:0]                     count_q;
    logic [NR_ENTRIES-1:0][RA_BITS-1:0]    rd_q;
    logic [NR_ENTRIES-1:0]                 rd_fpr_q;
    logic [NR_ENTRIES-1:0][THR_BITS-1:0]   thread_id_q;
    logic [NR_ENTRIES-1:0]                 valid_q;

    logic full;
    logic empty;
    logic issue_fire;
    logic commit_fire;

    assign full  = (count_q == COUNT_FULL);
    assign empty = (count_q == '0);

    // Ready does not look at the opposite handshake, so a full buffer cannot
    // accept an issue in the same cycle a commit frees a slot.
    assign issue_ready_o  = !full  && !rst_i;
    assign commit_ready_o = !empty && !rst_i;

    assign issue_fire  = issue_valid_i  && issue_ready_o;
    assign commit_fire = commit_valid_i && commit_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            rd_q         <= '0;
            rd_fpr_q     <= '0;
            thread_id_q  <= '0;
        end else if (flush_i) begin
            // Entry payloads are kept; only occupancy is discarded.
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
            count_q      <= '0;
            valid_q      <= '0;
        end else begin
            if (issue_fire) begin
                rd_q[issue_ptr_q]        <= issue_rd_i;
                rd_fpr_q[issue_ptr_q]    <= issue_rd_fpr_i;
                thread_id_q[issue_ptr_q] <= issue_thread_id_i;
                valid_q[issue_ptr_q]     <= 1'b1;
                issue_ptr_q              <= issue_ptr_q + 1'b1;
            end
            // Issue and commit slots can only coincide when full or empty,
            // and neither fire is possible in the matching case.
            if (commit_fire) begin
                valid_q[commit_ptr_q] <= 1'b0;
                commit_ptr_q          <= commit_ptr_q + 1'b1;
            end
            case ({issue_fire, commit_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign issue_trans_id_o   = issue_ptr_q;
    assign issue_pointer_o    = issue_ptr_q;
    assign commit_trans_id_o  = commit_ptr_q;
    assign commit_rd_o        = rd_q[commit_ptr_q];
    assign commit_rd_fpr_o    = rd_fpr_q[commit_ptr_q];
    assign commit_thread_id_o = thread_id_q[commit_ptr_q];

    assign rd_o           = rd_q;
    assign rd_fpr_o       = rd_fpr_q;
    assign thread_ids_o   = thread_id_q;
    assign still_issued_o = valid_q;
    assign count_o        = count_q;

endmodule

// File: tb/tb_sb_rd_tracker.sv
// Bench for sb_rd_tracker: directed scenarios then random traffic, checked against
// an occupancy model built from issue/commit totals and a slot payload memory.

module tb_sb_rd_tracker;

    localparam int NR  = 8;
    localparam int TIB = 3;
    localparam int RAS = 6;
    localparam int NTL = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic issue_valid = 1'b0;
    logic issue_ready;
    logic [RAS-1:0] issue_rd = '0;
    logic issue_rd_fpr = 1'b0;
    logic [NTL-1:0] issue_thread_id = '0;
    logic [TIB-1:0] issue_trans_id;
    logic commit_valid = 1'b0;
    logic commit_ready;
    logic [TIB-1:0] commit_trans_id;
    logic [RAS-1:0] commit_rd;
    logic commit_rd_fpr;
    logic [NTL-1:0] commit_thread_id;
    logic [NR-1:0][RAS-1:0] rd_vec;
    logic [NR-1:0] rd_fpr_vec;
    logic [NR-1:0][NTL-1:0] thread_ids;
    logic [NR-1:0] still_issued;
    logic [TIB-1:0] issue_pointer;
    logic [TIB:0] count;

    sb_rd_tracker dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .flush_i            (flush),
        .issue_valid_i      (issue_valid),
        .issue_ready_o      (issue_ready),
        .issue_rd_i         (issue_rd),
        .issue_rd_fpr_i     (issue_rd_fpr),
        .issue_thread_id_i  (issue_thread_id),
        .issue_trans_id_o   (issue_trans_id),
        .commit_valid_i     (commit_valid),
        .commit_ready_o     (commit_ready),
        .commit_trans_id_o  (commit_trans_id),
        .commit_rd_o        (commit_rd),
        .commit_rd_fpr_o    (commit_rd_fpr),
        .commit_thread_id_o (commit_thread_id),
        .rd_o               (rd_vec),
        .rd_fpr_o           (rd_fpr_vec),
        .thread_ids_o       (thread_ids),
        .still_issued_o     (still_issued),
        .issue_pointer_o    (issue_pointer),
        .count_o            (count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: totals since the last reset/flush plus a payload memory per slot.
    int n_iss = 0;
    int n_com = 0;
    int m_rd  [NR];
    int m_fpr [NR];
    int m_tid [NR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int occ;
        int cp;
        logic [NR-1:0] e_still;
        logic [NR-1:0][RAS-1:0] e_rd;
        logic [NR-1:0] e_fpr;
        logic [NR-1:0][NTL-1:0] e_tid;
        occ = n_iss - n_com;
        cp  = n_com % NR;
        for (int s = 0; s < NR; s++) begin
            e_still[s] = (((s - cp + NR) % NR) < occ);
            e_rd[s]    = RAS'(m_rd[s]);
            e_fpr[s]   = m_fpr[s][0];
            e_tid[s]   = NTL'(m_tid[s]);
        end
        chk("issue_ready", 64'(issue_ready), 64'(!rst && occ != NR));
        chk("commit_ready", 64'(commit_ready), 64'(!rst && occ != 0));
        chk("count", 64'(count), 64'(occ));
        chk("issue_pointer", 64'(issue_pointer), 64'(n_iss % NR));
        chk("issue_trans_id", 64'(issue_trans_id), 64'(n_iss % NR));
        chk("commit_trans_id", 64'(commit_trans_id), 64'(cp));
        chk("still_issued", 64'(still_issued), 64'(e_still));
        chk("rd", 64'(rd_vec), 64'(e_rd));
        chk("rd_fpr", 64'(rd_fpr_vec), 64'(e_fpr));
        chk("thread_ids", 64'(thread_ids), 64'(e_tid));
        chk("commit_rd", 64'(commit_rd), 64'(m_rd[cp]));
        chk("commit_rd_fpr", 64'(commit_rd_fpr), 64'(m_fpr[cp]));
        chk("commit_thread_id", 64'(commit_thread_id), 64'(m_tid[cp]));
    endtask

    // One clock: apply inputs, advance model with the edge, check #1 after it.
    task automatic step(input logic r, input logic f, input logic iv, input int rd,
                        input int fpr, input int tid, input logic cv);
        int occ;
        logic ifire;
        logic cfire;
        rst = r; flush = f; issue_valid = iv; commit_valid = cv;
        issue_rd = RAS'(rd); issue_rd_fpr = fpr[0]; issue_thread_id = NTL'(tid);
        occ   = n_iss - n_com;
        ifire = iv && occ < NR;
        cfire = cv && occ > 0;
        @(posedge clk);
        #1;
        if (r) begin
            n_iss = 0; n_com = 0;
            for (int s = 0; s < NR; s++) begin m_rd[s] = 0; m_fpr[s] = 0; m_tid[s] = 0; end
        end else if (f) begin
            n_iss = 0; n_com = 0;
        end else begin
            if (ifire) begin
                m_rd[n_iss % NR]  = rd;
                m_fpr[n_iss % NR] = fpr;
                m_tid[n_iss % NR] = tid;
                n_iss++;
            end
            if (cfire) n_com++;
        end
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic issue(input int rd, input int fpr, input int tid);
        step(1'b0, 1'b0, 1'b1, rd, fpr, tid, 1'b0);
    endtask

    task automatic commit();
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    endtask

    initial begin
        for (int s = 0; s < NR; s++) begin m_rd[s] = 0; m_fpr[s] = 0; m_tid[s] = 0; end

        // Reset, then idle.
        step(1'b1, 1'b0, 1'b1, 9, 1, 1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        idle();
        chk("idle_ready", 64'({issue_ready, commit_ready}), 64'(2'b10));
        chk("idle_still", 64'(still_issued), 64'h00);

        // Two issues of differing type/thread.
        issue(5, 0, 1);
        issue(3, 1, 0);
        chk("two_still", 64'(still_issued), 64'h03);
        chk("two_rd0", 64'(rd_vec[0]), 64'd5);
        chk("two_fpr", 64'(rd_fpr_vec), 64'h02);
        chk("two_tid0", 64'(thread_ids[0]), 64'd1);
        chk("two_count", 64'(count), 64'd2);

        // Fill to 8, then issue+commit together: only the commit lands.
        for (int i = 0; i < 6; i++) issue(10 + i, i % 2, i % 2);
        chk("full_count", 64'(count), 64'd8);
        step(1'b0, 1'b0, 1'b1, 42, 1, 1, 1'b1);
        chk("full_ic_count", 64'(count), 64'd7);
        chk("full_ic_iptr", 64'(issue_pointer), 64'd0);
        chk("full_ic_cptr", 64'(commit_trans_id), 64'd1);
        issue(42, 1, 1);
        chk("full_retry_count", 64'(count), 64'd8);
        chk("full_retry_rd0", 64'(rd_vec[0]), 64'd42);

        // Flush with 5 in flight and both handshakes asserted.
        for (int i = 0; i < 3; i++) commit();
        chk("pre_flush_count", 64'(count), 64'd5);
        step(1'b0, 1'b1, 1'b1, 7, 0, 0, 1'b1);
        chk("flush_still", 64'(still_issued), 64'h00);
        chk("flush_count", 64'(count), 64'd0);

        // Wrap-around: issue 6, commit 6, issue 4.
        for (int i = 0; i < 6; i++) issue(20 + i, 0, 0);
        for (int i = 0; i < 6; i++) commit();
        for (int i = 0; i < 4; i++) issue(30 + i, 1, 1);
        chk("wrap_iptr", 64'(issue_pointer), 64'd2);
        chk("wrap_cptr", 64'(commit_trans_id), 64'd6);
        chk("wrap_still", 64'(still_issued), 64'hC3);

        // Empty-buffer corner cases.
        step(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        commit();
        chk("empty_commit_count", 64'(count), 64'd0);
        step(1'b0, 1'b0, 1'b1, 17, 1, 0, 1'b1);
        chk("empty_ic_count", 64'(count), 64'd1);
        chk("empty_ic_still", 64'(still_issued), 64'h01);

        // Random traffic including occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            logic r, f, iv, cv;
            r  = ($urandom_range(0, 63) == 0);
            f  = ($urandom_range(0, 31) == 0);
            iv = ($urandom_range(0, 99) < 55);
            cv = ($urandom_range(0, 99) < 45);
            step(r, f, iv, int'($urandom_range(0, 63)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)), cv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
